vpu_instr_issue_ctrl: RTL and testbench

- Issue scheduler in front of the VPU instruction port.
- Arbitrates NUM_REQ instruction sources (e.g. scalar-core dispatch, replay, debug injector) round-robin onto one registered valid/ready instruction channel.
- Tracks instructions that are granted but not yet completed, and stalls issue at MAX_OUTSTANDING.
- Supports a pipeline flush that drops the held instruction and drains in-flight work before issue resumes.

---
 rtl/vpu_issue_pkg.sv | 13 +
 rtl/vpu_rr_arbiter.sv | 30 +++
 rtl/vpu_instr_issue_ctrl.sv | 95 +++++++++
 tb/tb_vpu_instr_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_issue_pkg.sv
// Shared types and helpers for the VPU instruction issue scheduler.
package vpu_issue_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, DRAIN} issue_state_e;

   localparam int INSTR_W_DEFAULT = 32;

   // Round-robin pointer moves just past the winner so it has lowest priority next time.
   function automatic int next_rr_ptr(input int idx, input int num_req);
      return (idx + 1 >= num_req) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/vpu_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module vpu_rr_arbiter #(
   parameter int NUM_REQ = 3,
   localparam int SRC_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SRC_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [SRC_W-1:0]   grant_idx
);

   logic             found;
   logic [SRC_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = SRC_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/vpu_instr_issue_ctrl.sv
// Issue scheduler: round-robin arbitration of instruction sources onto a registered
// valid/ready channel, with an in-flight credit limit and flush/drain handling.
module vpu_instr_issue_ctrl
   import vpu_issue_pkg::*;
#(
   parameter int NUM_REQ         = 3,
   parameter int INSTR_W         = INSTR_W_DEFAULT,
   parameter int MAX_OUTSTANDING = 4,
   localparam int SRC_W = $clog2(NUM_REQ),
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       vpu_valid,
   output logic [INSTR_W-1:0]         vpu_instr,
   output logic [SRC_W-1:0]           vpu_src,
   input  logic                       vpu_ready,
   input  logic                       cmt_valid,
   input  logic                       flush,
   output logic [CNT_W-1:0]           inflight,
   output logic                       busy,
   output logic                       cmt_err
);

   issue_state_e state, state_next;
   logic [CNT_W-1:0] inflight_q, base, inflight_next;
   logic [SRC_W-1:0] rr_ptr, arb_idx;
   logic [NUM_REQ-1:0] arb_grant;
   logic [NUM_REQ-1:0][INSTR_W-1:0] instr_arr;
   logic cmt_dec, drop, can_load, grant_any;

   assign instr_arr = req_instr;

   vpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   always_comb begin
      cmt_dec   = cmt_valid && (inflight_q != '0);
      base      = inflight_q - CNT_W'(cmt_dec);
      drop      = flush && vpu_valid && !vpu_ready;
      can_load  = !flush && ((state == IDLE) || ((state == HOLD) && vpu_ready));
      // Credit check uses the post-commit count so a retiring slot can be reused this cycle.
      grant_any = rst_n && can_load && (|req_valid) && (base < CNT_W'(MAX_OUTSTANDING));
      req_ready = grant_any ? arb_grant : '0;

      inflight_next = base;
      if (grant_any)
         inflight_next = inflight_next + CNT_W'(1);
      if (drop && (inflight_next != '0))
         inflight_next = inflight_next - CNT_W'(1);

      state_next = state;
      case (state)
         IDLE:    if (grant_any) state_next = HOLD;
         HOLD:    if (vpu_ready) state_next = grant_any ? HOLD : IDLE;
         DRAIN:   if (inflight_next == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush && (state != DRAIN))
         state_next = (inflight_next != '0) ? DRAIN : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         inflight_q <= '0;
         rr_ptr     <= '0;
         vpu_instr  <= '0;
         vpu_src    <= '0;
         cmt_err    <= 1'b0;
      end else begin
         state      <= state_next;
         inflight_q <= inflight_next;
         if (cmt_valid && (inflight_q == '0))
            cmt_err <= 1'b1;
         if (grant_any) begin
            vpu_instr <= instr_arr[arb_idx];
            vpu_src   <= arb_idx;
            rr_ptr    <= SRC_W'(next_rr_ptr(int'(arb_idx), NUM_REQ));
         end
      end
   end

   assign vpu_valid = (state == HOLD);
   assign inflight  = inflight_q;
   assign busy      = (state != IDLE) || (inflight_q != '0);

endmodule

// File: tb/tb_vpu_instr_issue_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// behavioural model built from the scheduler's rules.
module tb_vpu_instr_issue_ctrl;

   localparam int NUM_REQ = 3;
   localparam int INSTR_W = 32;
   localparam int MAX_OUT = 4;
   localparam int SRC_W   = 2;
   localparam int CNT_W   = 3;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*INSTR_W-1:0] req_instr;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       vpu_valid;
   logic [INSTR_W-1:0]         vpu_instr;
   logic [SRC_W-1:0]           vpu_src;
   logic                       vpu_ready;
   logic                       cmt_valid;
   logic                       flush;
   logic [CNT_W-1:0]           inflight;
   logic                       busy;
   logic                       cmt_err;

   vpu_instr_issue_ctrl #(.NUM_REQ(NUM_REQ), .INSTR_W(INSTR_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_instr (req_instr),
      .req_ready (req_ready),
      .vpu_valid (vpu_valid),
      .vpu_instr (vpu_instr),
      .vpu_src   (vpu_src),
      .vpu_ready (vpu_ready),
      .cmt_valid (cmt_valid),
      .flush     (flush),
      .inflight  (inflight),
      .busy      (busy),
      .cmt_err   (cmt_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: count of outstanding instructions, output slot, fairness pointer.
   int          m_count, m_src, m_ptr;
   bit          m_held, m_err, m_drain;
   logic [31:0] m_instr;
   logic [NUM_REQ-1:0] last_ready;
   int          grant_tally;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [NUM_REQ-1:0] rv);
      int s;
      for (int k = 0; k < NUM_REQ; k++) begin
         s = (m_ptr + k) % NUM_REQ;
         if (rv[s[SRC_W-1:0]]) return s;
      end
      return -1;
   endfunction

   task automatic resetModel();
      m_count = 0; m_src = 0; m_ptr = 0;
      m_held = 0; m_err = 0; m_drain = 0;
      m_instr = '0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      req_valid = '0; req_instr = '0; vpu_ready = 1'b0; cmt_valid = 1'b0; flush = 1'b0;
      #2;
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] rv, input logic [NUM_REQ*INSTR_W-1:0] ins,
                                input logic vr, input logic cm, input logic fl);
      int w, base, cnt;
      bit gnt, acc;
      req_valid = rv; req_instr = ins; vpu_ready = vr; cmt_valid = cm; flush = fl;
      #1;
      w    = winner(rv);
      base = m_count - ((cm && m_count > 0) ? 1 : 0);
      gnt  = !fl && !m_drain && (!m_held || vr) && (w >= 0) && (base < MAX_OUT);
      acc  = m_held && vr;
      checkOutput("req_ready", 32'(req_ready), gnt ? (32'd1 << w) : 32'd0);
      checkOutput("vpu_valid", 32'(vpu_valid), 32'(m_held));
      if (m_held) begin
         checkOutput("vpu_instr", vpu_instr, m_instr);
         checkOutput("vpu_src", 32'(vpu_src), 32'(m_src));
      end
      checkOutput("inflight", 32'(inflight), 32'(m_count));
      checkOutput("busy", 32'(busy), 32'(m_held || m_drain || (m_count != 0)));
      checkOutput("cmt_err", 32'(cmt_err), 32'(m_err));
      last_ready = req_ready;
      if (req_ready != '0) grant_tally++;
      @(posedge clk);
      if (cm && m_count == 0) m_err = 1;
      cnt = base + (gnt ? 1 : 0);
      if (fl && m_held && !vr && cnt > 0) cnt--;
      if (fl && !m_drain) begin
         m_held  = 0;
         m_drain = (cnt > 0);
      end else if (m_drain && cnt == 0) begin
         m_drain = 0;
      end
      if (gnt) begin
         m_held  = 1;
         m_instr = INSTR_W'(ins >> (w * INSTR_W));
         m_src   = w;
         m_ptr   = (w + 1) % NUM_REQ;
      end else if (acc) begin
         m_held = 0;
      end
      m_count = cnt;
      @(negedge clk);
   endtask

   logic [NUM_REQ*INSTR_W-1:0] ins;
   logic [INSTR_W-1:0]         held_word;

   initial begin
      grant_tally = 0;
      last_ready  = '0;
      rst_n = 1'b0;
      req_valid = '0; req_instr = '0; vpu_ready = 1'b0; cmt_valid = 1'b0; flush = 1'b0;
      resetModel();
      #1;
      checkOutput("reset_valid", 32'(vpu_valid), 32'd0);
      checkOutput("reset_instr", vpu_instr, 32'd0);
      checkOutput("reset_src", 32'(vpu_src), 32'd0);
      checkOutput("reset_inflight", 32'(inflight), 32'd0);
      checkOutput("reset_err", 32'(cmt_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request from source 1
      ins = {32'hAAAA_0002, 32'h0000_1057, 32'hAAAA_0000};
      applyStimulus(3'b010, ins, 1'b1, 1'b0, 1'b0);
      checkOutput("single_ready", 32'(last_ready), 32'b010);
      checkOutput("single_instr", vpu_instr, 32'h0000_1057);
      checkOutput("single_src", 32'(vpu_src), 32'd1);
      checkOutput("single_inflight", 32'(inflight), 32'd1);
      applyStimulus(3'b000, ins, 1'b1, 1'b1, 1'b0);

      // Fairness with continuous requests and one commit per cycle
      doReset();
      ins = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(3'b111, ins, 1'b1, (i > 0), 1'b0);
         checkOutput("fair_src", 32'(vpu_src), 32'(i % 3));
         checkOutput("fair_valid", 32'(vpu_valid), 32'd1);
      end
      applyStimulus(3'b000, ins, 1'b1, 1'b1, 1'b0);

      // Credit stall at MAX_OUT with no commits
      doReset();
      grant_tally = 0;
      for (int i = 0; i < 6; i++) applyStimulus(3'b111, ins, 1'b1, 1'b0, 1'b0);
      checkOutput("credit_grants", 32'(grant_tally), 32'd4);
      checkOutput("credit_inflight", 32'(inflight), 32'd4);
      applyStimulus(3'b111, ins, 1'b1, 1'b1, 1'b0);
      checkOutput("credit_regrant", 32'($countones(last_ready)), 32'd1);
      checkOutput("credit_hold4", 32'(inflight), 32'd4);
      for (int i = 0; i < 4; i++) applyStimulus(3'b000, ins, 1'b1, 1'b1, 1'b0);

      // Backpressure holds the output stable
      doReset();
      applyStimulus(3'b111, ins, 1'b0, 1'b0, 1'b0);
      held_word = vpu_instr;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3'b111, ins, 1'b0, 1'b0, 1'b0);
         checkOutput("bp_instr", vpu_instr, held_word);
         checkOutput("bp_src", 32'(vpu_src), 32'd0);
         checkOutput("bp_ready", 32'(last_ready), 32'd0);
      end
      applyStimulus(3'b111, ins, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_next_grant", 32'(last_ready), 32'b010);

      // Flush drops the held instruction, then drains
      doReset();
      applyStimulus(3'b111, ins, 1'b1, 1'b0, 1'b0);
      applyStimulus(3'b111, ins, 1'b1, 1'b0, 1'b0);
      applyStimulus(3'b111, ins, 1'b1, 1'b0, 1'b0);
      applyStimulus(3'b000, ins, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_pre_inflight", 32'(inflight), 32'd3);
      applyStimulus(3'b111, ins, 1'b0, 1'b0, 1'b1);
      checkOutput("flush_valid", 32'(vpu_valid), 32'd0);
      checkOutput("flush_inflight", 32'(inflight), 32'd2);
      applyStimulus(3'b111, ins, 1'b1, 1'b1, 1'b0);
      checkOutput("drain_ready1", 32'(last_ready), 32'd0);
      applyStimulus(3'b111, ins, 1'b1, 1'b1, 1'b1);
      checkOutput("drain_ready2", 32'(last_ready), 32'd0);
      applyStimulus(3'b111, ins, 1'b1, 1'b0, 1'b0);
      checkOutput("drain_resume", 32'($countones(last_ready)), 32'd1);
      applyStimulus(3'b000, ins, 1'b1, 1'b1, 1'b0);

      // Spurious commit and asynchronous reset mid-HOLD
      doReset();
      applyStimulus(3'b000, ins, 1'b1, 1'b1, 1'b0);
      checkOutput("err_flag", 32'(cmt_err), 32'd1);
      checkOutput("err_inflight", 32'(inflight), 32'd0);
      applyStimulus(3'b111, ins, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_valid", 32'(vpu_valid), 32'd0);
      checkOutput("async_inflight", 32'(inflight), 32'd0);
      checkOutput("async_ready", 32'(req_ready), 32'd0);
      checkOutput("async_err", 32'(cmt_err), 32'd0);
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         ins = {$urandom(), $urandom(), $urandom()};
         applyStimulus(NUM_REQ'($urandom_range(0, 7)), ins,
                       ($urandom_range(0, 3) != 0),
                       (m_count > 0) && ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
